// File: rtl/rf_scoreboard.sv
// rf_scoreboard: expected-register table; on CPU halt (PC self-loop) or timeout, scans the RF and compares masked entries.
// Latency: scan takes NREGS+RD_LAT cycles after halt/timeout detection; results hold in DONE until start or reset.
// Backpressure: none; table writes are dropped outside IDLE/DONE. Optional RF_SCB_XCHECK_EN: 4-state compare + mismatch log.
module rf_scoreboard #(
   parameter int XLEN          = 32,
   parameter int NREGS         = 32,
   parameter int STABLE_CYCLES = 8,
   parameter int TIMEOUT       = 100000,
   parameter int RD_LAT        = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [XLEN-1:0]            pc,
   input  logic                       exp_we,
   input  logic [$clog2(NREGS)-1:0]   exp_idx,
   input  logic [XLEN-1:0]            exp_val,
   input  logic                       exp_clr,
   output logic [$clog2(NREGS)-1:0]   rf_raddr,
   input  logic [XLEN-1:0]            rf_rdata,
   output logic                       busy,
   output logic                       done,
   output logic                       pass,
   output logic                       timeout,
   output logic [$clog2(NREGS+1)-1:0] err_count,
   output logic [$clog2(NREGS+1)-1:0] chk_count,
   output logic [$clog2(NREGS)-1:0]   first_err_idx,
   output logic [XLEN-1:0]            first_err_got,
   output logic [XLEN-1:0]            first_err_exp
);

   localparam int IW = $clog2(NREGS);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(STABLE_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, RUN, SCAN, DONE} state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   exp_tab [NREGS];
   logic [NREGS-1:0]  mask_q;
   logic [XLEN-1:0]   prev_pc;
   logic [TW-1:0]     cyc_cnt;
   logic [SW-1:0]     stb_cnt;
   logic              issue_done;
   logic              cmp_vld;
   logic [IW-1:0]     cmp_idx;
   logic [XLEN-1:0]   cmp_exp;
   logic              cmp_msk;
   logic              mism;
   logic              idle_or_done, go, pc_same, stb_hit, cyc_hit, issue, last_cmp;

   assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
   assign go           = start && idle_or_done;
   assign pc_same      = (pc == prev_pc);
   // The counter holds the number of consecutive equal pairs; the one that would make it STABLE_CYCLES-1 ends RUN.
   assign stb_hit      = (state_q == RUN) && pc_same && (stb_cnt == SW'(STABLE_CYCLES - 2));
   assign cyc_hit      = (state_q == RUN) && (cyc_cnt == TW'(TIMEOUT - 1));
   assign issue        = (state_q == SCAN) && !issue_done;
   assign last_cmp     = cmp_vld && (cmp_idx == IW'(NREGS - 1));

   assign busy = (state_q == RUN) || (state_q == SCAN);
   assign done = (state_q == DONE);
   assign pass = done && (err_count == '0) && !timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (start) state_d = RUN;
         RUN:        if (stb_hit || cyc_hit) state_d = SCAN;
         SCAN:       if (last_cmp) state_d = DONE;
         default:    state_d = IDLE;
      endcase
   end

   // Clear applies before the write so a same-cycle write survives with its mask bit set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q <= '0;
         for (int i = 0; i < NREGS; i++) exp_tab[i] <= '0;
      end else if (idle_or_done) begin
         if (exp_clr) mask_q <= '0;
         if (exp_we) begin
            exp_tab[exp_idx] <= (exp_idx == '0) ? '0 : exp_val;
            mask_q[exp_idx]  <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_pc <= '0;
         cyc_cnt <= '0;
         stb_cnt <= '0;
      end else begin
         prev_pc <= pc;
         if (go) begin
            cyc_cnt <= '0;
            stb_cnt <= '0;
         end else if (state_q == RUN) begin
            cyc_cnt <= cyc_cnt + 1'b1;
            stb_cnt <= pc_same ? stb_cnt + 1'b1 : '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_raddr   <= '0;
         issue_done <= 1'b0;
      end else if (state_q == RUN && (stb_hit || cyc_hit)) begin
         rf_raddr   <= '0;
         issue_done <= 1'b0;
      end else if (issue) begin
         if (rf_raddr == IW'(NREGS - 1)) issue_done <= 1'b1;
         else                            rf_raddr   <= rf_raddr + 1'b1;
      end
   end

   generate
      if (RD_LAT == 0) begin : g_lat0
         assign cmp_vld = issue;
         assign cmp_idx = rf_raddr;
      end else begin : g_lat1
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cmp_vld <= 1'b0;
               cmp_idx <= '0;
            end else begin
               cmp_vld <= issue;
               cmp_idx <= rf_raddr;
            end
         end
      end
   endgenerate

   assign cmp_exp = exp_tab[cmp_idx];
   assign cmp_msk = mask_q[cmp_idx];

`ifdef RF_SCB_XCHECK_EN
   assign mism = (rf_rdata !== cmp_exp);
`else
   assign mism = (rf_rdata != cmp_exp);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timeout       <= 1'b0;
         err_count     <= '0;
         chk_count     <= '0;
         first_err_idx <= '0;
         first_err_got <= '0;
         first_err_exp <= '0;
      end else if (go) begin
         timeout       <= 1'b0;
         err_count     <= '0;
         chk_count     <= '0;
         first_err_idx <= '0;
         first_err_got <= '0;
         first_err_exp <= '0;
      end else begin
         if (cyc_hit) timeout <= 1'b1;
         if (cmp_vld && cmp_msk) begin
            chk_count <= chk_count + 1'b1;
            if (mism) begin
               err_count <= err_count + 1'b1;
               if (err_count == '0) begin
                  first_err_idx <= cmp_idx;
                  first_err_got <= rf_rdata;
                  first_err_exp <= cmp_exp;
               end
            end
         end
      end
   end

`ifdef RF_SCB_XCHECK_EN
   always_ff @(posedge clk) begin
      if (rst_n && cmp_vld && cmp_msk && mism)
         $display("x%0d exp %h got %h", cmp_idx, cmp_exp, rf_rdata);
   end
`endif

endmodule

// File: tb/tb_rf_scoreboard.sv
// Bench for rf_scoreboard: random table/RF contents and PC traces against an outcome model built from arrays.
module tb_rf_scoreboard;
   localparam int XLEN = 32, NREGS = 32, SC = 8, TMO = 200, RDL = 1;
   localparam int IW = $clog2(NREGS), CW = $clog2(NREGS + 1);

   logic            clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic            exp_we = 1'b0, exp_clr = 1'b0;
   logic [IW-1:0]   exp_idx = '0;
   logic [XLEN-1:0] exp_val = '0, pc = '0;
   logic [IW-1:0]   rf_raddr;
   logic [XLEN-1:0] rf_rdata, rf_q = '0;
   logic            busy, done, pass, timeout;
   logic [CW-1:0]   err_count, chk_count;
   logic [IW-1:0]   first_err_idx;
   logic [XLEN-1:0] first_err_got, first_err_exp;

   int total = 0, bad = 0;
   logic [XLEN-1:0] rf_mem [NREGS];
   logic [XLEN-1:0] m_exp  [NREGS];
   bit              m_msk  [NREGS];

   rf_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .STABLE_CYCLES(SC), .TIMEOUT(TMO), .RD_LAT(RDL)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pc(pc),
      .exp_we(exp_we), .exp_idx(exp_idx), .exp_val(exp_val), .exp_clr(exp_clr),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
      .busy(busy), .done(done), .pass(pass), .timeout(timeout),
      .err_count(err_count), .chk_count(chk_count),
      .first_err_idx(first_err_idx), .first_err_got(first_err_got), .first_err_exp(first_err_exp)
   );

   always #5 clk = ~clk;

   // Register file model with a registered read port
   always @(posedge clk) rf_q <= rf_mem[rf_raddr];
   assign rf_rdata = (RDL == 1) ? rf_q : rf_mem[rf_raddr];

   initial begin
      #3000000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tbl_wr(input bit clr, input bit we, input int idx, input logic [XLEN-1:0] val);
      @(negedge clk);
      exp_clr = clr; exp_we = we; exp_idx = IW'(idx); exp_val = val;
      @(negedge clk);
      exp_clr = 1'b0; exp_we = 1'b0;
      if (clr) for (int i = 0; i < NREGS; i++) m_msk[i] = 1'b0;
      if (we) begin
         m_exp[idx] = (idx == 0) ? '0 : val;
         m_msk[idx] = 1'b1;
      end
   endtask

   // pc at RUN cycle t (start cycle is t=-1) is base+min(t+1,frz): constant from RUN cycle frz-1 on.
   task automatic run_check(input string tag, input int frz);
      int n, t, chk, err, fi, r_exp;
      bit to_exp;
      logic [XLEN-1:0] base, fg, fe;
      chk = 0; err = 0; fi = 0; fg = '0; fe = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (m_msk[i]) begin
            chk++;
            if (rf_mem[i] != m_exp[i]) begin
               if (err == 0) begin fi = i; fg = rf_mem[i]; fe = m_exp[i]; end
               err++;
            end
         end
      end
      // STABLE equal samples end at RUN cycle frz+SC-2; timeout wins at RUN cycle TMO-1
      to_exp = (frz + SC - 2) >= (TMO - 1);
      r_exp  = to_exp ? TMO : frz + SC - 1;
      base   = $urandom;
      @(negedge clk);
      start = 1'b1; pc = base;
      @(negedge clk);
      start = 1'b0; n = 0; t = 0;
      while (busy && n < 5000) begin
         pc      = base + XLEN'((t + 1 < frz) ? t + 1 : frz);
         exp_we  = (t == 2);
         exp_clr = (t == 2);
         exp_idx = IW'($urandom_range(NREGS - 1, 1));
         exp_val = $urandom;
         t++; n++;
         @(negedge clk);
      end
      exp_we = 1'b0; exp_clr = 1'b0;
      check({tag, ".cycles"},  n,             r_exp + NREGS + RDL);
      check({tag, ".done"},    done,          1);
      check({tag, ".timeout"}, timeout,       to_exp);
      check({tag, ".pass"},    pass,          (err == 0) && !to_exp);
      check({tag, ".chk"},     chk_count,     chk);
      check({tag, ".err"},     err_count,     err);
      check({tag, ".fidx"},    first_err_idx, fi);
      check({tag, ".fgot"},    first_err_got, fg);
      check({tag, ".fexp"},    first_err_exp, fe);
      check({tag, ".raddr"},   rf_raddr,      NREGS - 1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".busy"},    busy,          0);
      check({tag, ".done"},    done,          0);
      check({tag, ".pass"},    pass,          0);
      check({tag, ".timeout"}, timeout,       0);
      check({tag, ".err"},     err_count,     0);
      check({tag, ".chk"},     chk_count,     0);
      check({tag, ".fidx"},    first_err_idx, 0);
      check({tag, ".fgot"},    first_err_got, 0);
      check({tag, ".fexp"},    first_err_exp, 0);
      check({tag, ".raddr"},   rf_raddr,      0);
   endtask

   initial begin
      int ld_idx [6];
      logic [XLEN-1:0] v;
      ld_idx = '{8, 9, 18, 19, 20, 21};
      for (int i = 0; i < NREGS; i++) begin
         rf_mem[i] = (i == 0) ? '0 : $urandom;
         m_exp[i]  = '0;
         m_msk[i]  = 1'b0;
      end
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      for (int k = 0; k < 6; k++) begin
         tbl_wr(0, 1, ld_idx[k], XLEN'(k + 1));
         rf_mem[ld_idx[k]] = XLEN'(k + 1);
      end
      run_check("match", 50);

      rf_mem[19] = 7; rf_mem[21] = 0;
      run_check("two_err", 50);
      check("two_err.idx19", first_err_idx, 19);
      check("two_err.got7",  first_err_got, 7);
      check("two_err.exp4",  first_err_exp, 4);
      rf_mem[19] = 4; rf_mem[21] = 6;

      run_check("tmo", 1000);

      tbl_wr(0, 1, 31, 32'h1234_5678);
      rf_mem[31] = 32'h1234_5679;
      run_check("x31", 3);
      check("x31.idx", first_err_idx, 31);

      tbl_wr(0, 1, 0, 32'hDEAD);
      run_check("x0", 0);

      tbl_wr(1, 1, 5, 32'hCAFE_0005);
      rf_mem[5] = 32'hCAFE_0005;
      run_check("clrwe", 10);
      check("clrwe.one", chk_count, 1);

      tbl_wr(1, 0, 0, '0);
      run_check("clr", 5);

      for (int r = 0; r < 6; r++) begin
         if ($urandom_range(1, 0) == 1) tbl_wr(1, 0, 0, '0);
         for (int w = 0; w < int'($urandom_range(8, 0)); w++) begin
            int idx;
            idx = $urandom_range(NREGS - 1, 0);
            v = $urandom;
            tbl_wr(0, 1, idx, v);
            if (idx != 0) rf_mem[idx] = ($urandom_range(3, 0) == 0) ? v ^ (32'h1 << $urandom_range(31, 0)) : v;
         end
         run_check("rand", ($urandom_range(7, 0) == 0) ? 300 : int'($urandom_range(60, 0)));
      end

      @(negedge clk);
      start = 1'b1; pc = 32'h100;
      @(negedge clk);
      start = 1'b0;
      repeat (SC + 10) @(negedge clk);
      check("mid.busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NREGS; i++) begin m_exp[i] = '0; m_msk[i] = 1'b0; end
      run_check("empty", 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
